// File: rtl/mcu_dmi_multi_req_sync.sv
// mcu_dmi_multi_req_sync
// Brings NUM_CH request levels from the JTAG/TCK domain into the core clock
// domain. Each channel's selected edge becomes a pending event. Pending events
// are handed to a core-side consumer one at a time over a valid/ready
// handshake, using round-robin arbitration across channels.
// For DMI, channel 0 is the read request and channel 1 is the write request.
//
// Ports
//   clk          core clock, the only clock
//   rst          synchronous active-high reset
//   async_req    per-channel request levels from the TCK domain
//   req_valid    an event is being offered
//   req_ch       one-hot channel of the offered event, zero when idle
//   req_ready    consumer accepts the offered event
//   pending      per-channel pending-event bits
//   overrun      sticky per-channel overrun flags (event dropped)
//   overrun_clr  write-1-to-clear for overrun
module mcu_dmi_multi_req_sync #(
  parameter int NUM_CH      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_req,
  output logic              req_valid,
  output logic [NUM_CH-1:0] req_ch,
  input  logic              req_ready,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] overrun,
  input  logic [NUM_CH-1:0] overrun_clr
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e                           state_q, state_d;
  logic [SYNC_STAGES:0][NUM_CH-1:0] sync_q;
  logic [NUM_CH-1:0]                pending_q, pending_d;
  logic [NUM_CH-1:0]                overrun_q, overrun_d;
  logic [NUM_CH-1:0]                grant_q, grant_d;
  logic [IW-1:0]                    start_q, start_d;

  logic [NUM_CH-1:0] syncNew, syncOld, ev, accVec;
  logic [NUM_CH-1:0] rrReq, rrWin;
  logic [IW-1:0]     rrStart, accIdx, accNext;
  logic              accept, rrFound;
  int                rrIdx;

  // Synchroniser chain: stage 0 samples the raw level and each stage shifts up.
  // The top two stages feed the edge detector.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-1:0], async_req};
  end

  // Edge detection on the last two synchronised stages.
  always_comb begin
    syncNew = sync_q[SYNC_STAGES-1];
    syncOld = sync_q[SYNC_STAGES];
    case (EDGE_MODE)
      0:       ev = syncNew & ~syncOld;
      1:       ev = ~syncNew & syncOld;
      default: ev = syncNew ^ syncOld;
    endcase
  end

  // Accept is decoded from registered state only, so req_ready never reaches
  // req_valid or req_ch combinationally.
  always_comb begin
    accept = (state_q == OFFER) && req_ready;
    accVec = accept ? grant_q : '0;
    accIdx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) accIdx = IW'(i);
    end
    accNext = (accIdx == IW'(NUM_CH - 1)) ? '0 : accIdx + IW'(1);
  end

  // An event on a channel that is being accepted in the same cycle is queued
  // as the next pending event. Only an event that lands on a still-held pending
  // bit is dropped and flagged. A new set beats a simultaneous clear.
  always_comb begin
    pending_d = (pending_q & ~accVec) | ev;
    overrun_d = (overrun_q & ~overrun_clr) | (ev & pending_q & ~accVec);
  end

  // Round-robin request set and start point.
  // On accept, the search uses the post-accept pending set, starting just
  // above the accepted channel. Otherwise it uses the registered pending bits.
  always_comb begin
    rrReq   = (state_q == OFFER) ? pending_d : pending_q;
    rrStart = accept ? accNext : start_q;
  end

  // First requesting channel at or after rrStart, wrapping modulo NUM_CH.
  always_comb begin
    rrWin   = '0;
    rrFound = 1'b0;
    rrIdx   = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      rrIdx = (int'(rrStart) + i) % NUM_CH;
      if (!rrFound && rrReq[rrIdx[IW-1:0]]) begin
        rrWin[rrIdx[IW-1:0]] = 1'b1;
        rrFound              = 1'b1;
      end
    end
  end

  // Next-state logic.
  // In OFFER the grant is frozen until accepted.
  // An accept with further work reloads the grant and stays in OFFER, so
  // back-to-back offers have no bubble.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d = rrWin;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          start_d = accNext;
          if (|pending_d) begin
            grant_d = rrWin;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      overrun_q <= '0;
      grant_q   <= '0;
      start_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      grant_q   <= grant_d;
      start_q   <= start_d;
    end
  end

  assign req_valid = (state_q == OFFER);
  assign req_ch    = req_valid ? grant_q : '0;
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule
